// File: rtl/b_bus_mux_seq_pkg.sv
// B-bus source mux shared definitions:
// state encoding, slot map and default widths.
package bbus_pkg;

  localparam int BBUS_DATA_W  = 32;
  localparam int BBUS_NUM_SRC = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2
  } bbus_st_t;

  localparam int SRC_MDR  = 1;
  localparam int SRC_K0   = 2;
  localparam int SRC_K1   = 3;
  localparam int SRC_K2   = 4;
  localparam int SRC_K3   = 5;
  localparam int SRC_K4   = 6;
  localparam int SRC_K5   = 7;
  localparam int SRC_K6   = 8;
  localparam int SRC_K7   = 9;
  localparam int SRC_K8   = 10;
  localparam int SRC_P1   = 11;
  localparam int SRC_P2   = 12;
  localparam int SRC_P3   = 13;
  localparam int SRC_DP   = 14;
  localparam int SRC_CV   = 15;
  localparam int SRC_I    = 16;
  localparam int SRC_MBRU = 17;
  localparam int SRC_PC   = 19;
  localparam int SRC_MAR  = 23;

endpackage

// File: rtl/b_bus_mux_seq_if.sv
// Request/stream bundle between control unit
// and the B-bus source mux.
interface b_bus_mux_seq_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_burst;
  logic [SEL_W-1:0]  req_sel;
  logic [CNT_W-1:0]  req_len;
  logic              hold;
  logic [DATA_W-1:0] bus_out;
  logic              bus_valid;
  logic              bus_last;
  logic              sel_err;
  logic              err_clr;

  modport master (
    output req_valid, req_burst, req_sel,
    output req_len, hold, err_clr,
    input  req_ready, bus_out, bus_valid,
    input  bus_last, sel_err
  );

  modport slave (
    input  req_valid, req_burst, req_sel,
    input  req_len, hold, err_clr,
    output req_ready, bus_out, bus_valid,
    output bus_last, sel_err
  );
endinterface

// File: rtl/bbus_src_select.sv
// Indexed read of the packed source slots;
// unmapped indices read as zero and flag oor.
module bbus_src_select #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 24,
  parameter int SEL_W   = 5
) (
  input  logic [NUM_SRC*DATA_W-1:0] src_flat,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         data,
  output logic                      oor
);

  logic hit;

  // one-hot style scan so no slice can run past src_flat
  always_comb begin
    data = '0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        data = src_flat[i*DATA_W +: DATA_W];
        hit  = 1'b1;
      end
    end
    oor = ~hit;
  end

endmodule

// File: rtl/b_bus_mux_seq.sv
// Registered B-bus source mux with single reads
// and self-sequencing bursts over a slot range.
module b_bus_mux_seq
  import bbus_pkg::*;
#(
  parameter int DATA_W  = BBUS_DATA_W,
  parameter int NUM_SRC = BBUS_NUM_SRC,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_flat,
  b_bus_mux_seq_if.slave            bif
);

  bbus_st_t          st_q, st_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              lst_q, lst_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] word;
  logic              oor;

  bbus_src_select #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_sel (
    .src_flat (src_flat),
    .sel      (idx_q),
    .data     (word),
    .oor      (oor)
  );

  // next state, counters and output word
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    rem_d = rem_q;
    out_d = out_q;
    vld_d = 1'b0;
    lst_d = 1'b0;
    err_d = err_q & ~bif.err_clr;
    unique case (st_q)
      ST_IDLE: begin
        if (bif.req_valid) begin
          idx_d = bif.req_sel;
          rem_d = CNT_W'(1);
          if (bif.req_burst && bif.req_len != '0)
            rem_d = bif.req_len;
          st_d = bif.req_burst ? ST_BURST
                               : ST_SINGLE;
        end
      end
      ST_SINGLE, ST_BURST: begin
        if (bif.hold) begin
          vld_d = vld_q;
          lst_d = lst_q;
        end else begin
          out_d = word;
          vld_d = 1'b1;
          lst_d = (rem_q == CNT_W'(1));
          if (oor)
            err_d = 1'b1;
          idx_d = idx_q + SEL_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (lst_d)
            st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      idx_q <= '0;
      rem_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      lst_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      out_q <= out_d;
      vld_q <= vld_d;
      lst_q <= lst_d;
      err_q <= err_d;
    end
  end

  assign bif.req_ready = (st_q == ST_IDLE);
  assign bif.bus_out   = out_q;
  assign bif.bus_valid = vld_q;
  assign bif.bus_last  = lst_q;
  assign bif.sel_err   = err_q;

endmodule

// File: tb/tb_b_bus_mux_seq.sv
// Bench for b_bus_mux_seq: directed scenarios
// plus random traffic against a queue model.
module tb_b_bus_mux_seq;

  localparam int DW  = 32;
  localparam int NS  = 24;
  localparam int SW  = 5;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic rst;
  logic [NS*DW-1:0] src_flat;
  logic [DW-1:0]    src [NS];

  int checks   = 0;
  int failures = 0;

  b_bus_mux_seq_if #(.DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) bif();

  b_bus_mux_seq #(
    .DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_flat (src_flat),
    .bif      (bif)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_flat = '0;
    for (int i = 0; i < NS; i++)
      src_flat[i*DW +: DW] = src[i];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: a request becomes a queue of slot
  // indices; each non-held edge emits the head of it
  int         mq[$];
  logic [31:0] e_out;
  bit          e_vld, e_lst, e_err;
  bit          m_set;
  int          m_i, m_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      e_out = 0; e_vld = 0; e_lst = 0; e_err = 0;
    end else begin
      m_set = 0;
      if (mq.size() > 0) begin
        if (!bif.hold) begin
          m_i   = mq.pop_front();
          e_out = (m_i < NS) ? src[m_i] : 32'h0;
          m_set = (m_i >= NS);
          e_vld = 1;
          e_lst = (mq.size() == 0);
        end
      end else begin
        e_vld = 0;
        e_lst = 0;
        if (bif.req_valid) begin
          m_n = 1;
          if (bif.req_burst)
            m_n = (bif.req_len == 0) ? 1 : int'(bif.req_len);
          for (int k = 0; k < m_n; k++)
            mq.push_back((int'(bif.req_sel) + k) % 32);
        end
      end
      if (m_set) e_err = 1;
      else if (bif.err_clr) e_err = 0;
    end
  end

  // continuous comparison against the model
  always @(negedge clk) begin
    chk("m_out", bif.bus_out, e_out);
    chk("m_vld", 32'(bif.bus_valid), 32'(e_vld));
    chk("m_lst", 32'(bif.bus_last), 32'(e_lst));
    chk("m_err", 32'(bif.sel_err), 32'(e_err));
    chk("m_rdy", 32'(bif.req_ready),
        32'(mq.size() == 0));
  end

  task automatic issue(input bit b,
                       input logic [4:0] s,
                       input logic [4:0] l);
    int n;
    n = 0;
    while (!bif.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bif.req_ready)
      chk("ready_timeout", 32'(bif.req_ready), 1);
    bif.req_valid = 1'b1;
    bif.req_burst = b;
    bif.req_sel   = s;
    bif.req_len   = l;
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.req_sel   = 5'($urandom);
    bif.req_len   = 5'($urandom);
    bif.req_burst = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    bif.req_valid = 0; bif.req_burst = 0;
    bif.req_sel = 0; bif.req_len = 0;
    bif.hold = 0; bif.err_clr = 0;
    for (int i = 0; i < NS; i++) src[i] = $urandom;
    src[SW-4] = 32'hDEADBEEF;
    for (int i = 0; i < 9; i++) src[2+i] = 32'h10 + i;
    src[22] = 32'hAAAA0022;
    src[23] = 32'hAAAA0023;
    repeat (2) @(negedge clk);
    chk("rst_out", bif.bus_out, 0);
    chk("rst_vld", 32'(bif.bus_valid), 0);
    chk("rst_rdy", 32'(bif.req_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // single read of slot 1
    issue(0, 5'd1, 5'd7);
    chk("single_busy", 32'(bif.req_ready), 0);
    @(negedge clk);
    chk("single_out", bif.bus_out, 32'hDEADBEEF);
    chk("single_vld", 32'(bif.bus_valid), 1);
    chk("single_lst", 32'(bif.bus_last), 1);
    chk("single_rdy", 32'(bif.req_ready), 1);

    // kernel burst K0..K8
    issue(1, 5'd2, 5'd9);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("kern_out", bif.bus_out, 32'h10 + k);
      chk("kern_lst", 32'(bif.bus_last),
          32'(k == 8));
    end
    chk("kern_rdy", 32'(bif.req_ready), 1);

    // same burst with a 3-cycle stall after word 4
    issue(1, 5'd2, 5'd9);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_pre", bif.bus_out, 32'h10 + k);
    end
    bif.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_out", bif.bus_out, 32'h13);
      chk("hold_vld", 32'(bif.bus_valid), 1);
    end
    bif.hold = 1'b0;
    for (int k = 4; k < 9; k++) begin
      @(negedge clk);
      chk("hold_post", bif.bus_out, 32'h10 + k);
      chk("hold_lst", 32'(bif.bus_last),
          32'(k == 8));
    end
    @(negedge clk);
    chk("hold_done", 32'(bif.bus_valid), 0);

    // illegal indices at the top of the map
    issue(1, 5'd22, 5'd4);
    @(negedge clk);
    chk("ill_w0", bif.bus_out, 32'hAAAA0022);
    chk("ill_e0", 32'(bif.sel_err), 0);
    @(negedge clk);
    chk("ill_w1", bif.bus_out, 32'hAAAA0023);
    @(negedge clk);
    chk("ill_w2", bif.bus_out, 0);
    chk("ill_v2", 32'(bif.bus_valid), 1);
    chk("ill_e2", 32'(bif.sel_err), 1);
    bif.err_clr = 1'b1;
    @(negedge clk);
    chk("ill_w3", bif.bus_out, 0);
    chk("ill_l3", 32'(bif.bus_last), 1);
    chk("ill_setwin", 32'(bif.sel_err), 1);
    bif.err_clr = 1'b0;
    @(negedge clk);
    chk("ill_stick", 32'(bif.sel_err), 1);
    bif.err_clr = 1'b1;
    @(negedge clk);
    chk("ill_clr", 32'(bif.sel_err), 0);
    bif.err_clr = 1'b0;

    // zero length and index wrap
    issue(1, 5'd31, 5'd0);
    @(negedge clk);
    chk("len0_out", bif.bus_out, 0);
    chk("len0_lst", 32'(bif.bus_last), 1);
    chk("len0_err", 32'(bif.sel_err), 1);
    @(negedge clk);
    chk("len0_one", 32'(bif.bus_valid), 0);
    issue(1, 5'd31, 5'd2);
    @(negedge clk);
    chk("wrap_w0", bif.bus_out, 0);
    chk("wrap_l0", 32'(bif.bus_last), 0);
    @(negedge clk);
    chk("wrap_w1", bif.bus_out, src[0]);
    chk("wrap_l1", 32'(bif.bus_last), 1);

    // async reset during the 5th word
    issue(1, 5'd2, 5'd9);
    repeat (5) @(negedge clk);
    chk("ar_w4", bif.bus_out, 32'h14);
    #1 rst = 1'b1;
    #1;
    chk("ar_vld", 32'(bif.bus_valid), 0);
    chk("ar_out", bif.bus_out, 0);
    chk("ar_rdy", 32'(bif.req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("ar_quiet", 32'(bif.bus_valid), 0);
    end

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bif.req_valid = ($urandom % 3) == 0;
      bif.req_burst = 1'($urandom);
      bif.req_sel   = ($urandom % 4 == 0)
                    ? 5'($urandom_range(20, 31))
                    : 5'($urandom);
      bif.req_len   = ($urandom % 4 == 0)
                    ? 5'($urandom)
                    : 5'($urandom % 10);
      bif.hold      = ($urandom % 5) == 0;
      bif.err_clr   = ($urandom % 10) == 0;
      if ($urandom % 8 == 0)
        src[$urandom % NS] = $urandom;
    end
    @(negedge clk);
    bif.req_valid = 0;
    bif.hold = 0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
